// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: one request in flight,
// byte-lane stores into a word RAM, aligned and extended load data, error flag.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state_o
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds its payload stable while valid is high, and ready never
  // depends on the peer's valid.

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [2:0]     f3_q, f3_d;
  logic [AW+1:0]  addr_q, addr_d;
  logic           cerr_q, cerr_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

  logic [31:0]    mem [DEPTH_WORDS];
  logic           accept, wr_en;
  logic [3:0]     be;
  logic [31:0]    wlanes;

  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic misaligned, illegal, out_of_range;
    misaligned   = (f3[1:0] == 2'b01 && addr[0]) ||
                   (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    illegal      = we ? (f3 > 3'b010)
                      : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    out_of_range = {2'b00, addr[31:2]} >= 32'(DEPTH_WORDS);
    return misaligned || illegal || out_of_range;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  assign req_ready   = rst_n && (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state_o = state_q;

  assign accept = req_valid && req_ready;
  assign wr_en  = accept && req_we && !req_error(req_we, req_funct3, req_addr);

  // Replicate store data across lanes so the byte enables alone pick the target.
  always_comb begin
    be     = 4'b0000;
    wlanes = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be     = 4'b0001 << req_addr[1:0];
        wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be     = req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[req_addr[AW+1:2]][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    cerr_d  = cerr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = 4'(LATENCY - 1);
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr[AW+1:0];
          cerr_d  = req_error(req_we, req_funct3, req_addr);
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // RAM is sampled here so the load observes every earlier store.
          state_d = S_RESP;
          err_d   = cerr_q;
          rdata_d = (cerr_q || we_q) ? 32'h0
                  : load_extend(f3_q, addr_q[1:0], mem[addr_q[AW+1:2]]);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      cerr_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      cerr_q  <= cerr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of load/store vectors plus
// hand-written backpressure and mid-operation reset sequences.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Driver: present a request, wait for the response, then complete it.
  task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_checked(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    run_req(name, we, f3, addr, wdata, rd, er, lat);
    check({name, " latency"}, 32'(lat), 32'(LAT));
    check({name, " rdata"}, rd, exp_rdata);
    check({name, " err"}, 32'(er), {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] held;
    int          lat;
    int          stray;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release req_ready", 32'(req_ready), 32'd1);

    // Vector table (funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU)
    add_vec("sw_10",      1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0);
    add_vec("lw_10",      0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    add_vec("lb_13",      0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 0);
    add_vec("lbu_13",     0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 0);
    add_vec("lh_10",      0, 3'b001, 32'h10,   32'h0,        32'hFFFFBEEF, 0);
    add_vec("lhu_12",     0, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 0);
    add_vec("sb_11",      1, 3'b000, 32'h11,   32'hAAAAAA55, 32'h0,        0);
    add_vec("lw_after_sb",0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 0);
    add_vec("sh_12",      1, 3'b001, 32'h12,   32'hBBBB1234, 32'h0,        0);
    add_vec("lw_after_sh",0, 3'b010, 32'h10,   32'h0,        32'h123455EF, 0);
    add_vec("lw_mis",     0, 3'b010, 32'h12,   32'h0,        32'h0,        1);
    add_vec("sh_mis",     1, 3'b001, 32'h11,   32'hFFFFFFFF, 32'h0,        1);
    add_vec("lw_oor",     0, 3'b010, 32'(DEPTH*4), 32'h0,    32'h0,        1);
    add_vec("sw_oor_hi",  1, 3'b010, 32'h80000010, 32'h0,    32'h0,        1);
    add_vec("ld_f3_011",  0, 3'b011, 32'h10,   32'h0,        32'h0,        1);
    add_vec("ld_f3_110",  0, 3'b110, 32'h10,   32'h0,        32'h0,        1);
    add_vec("st_f3_100",  1, 3'b100, 32'h10,   32'h0,        32'h0,        1);
    add_vec("sw_mis",     1, 3'b010, 32'h13,   32'h0,        32'h0,        1);
    add_vec("lw_nochange",0, 3'b010, 32'h10,   32'h0,        32'h123455EF, 0);
    add_vec("lb_10",      0, 3'b000, 32'h10,   32'h0,        32'hFFFFFFEF, 0);
    add_vec("lb_11",      0, 3'b000, 32'h11,   32'h0,        32'h00000055, 0);
    add_vec("lh_12",      0, 3'b001, 32'h12,   32'h0,        32'h00001234, 0);
    add_vec("sw_last",    1, 3'b010, 32'(DEPTH*4-4), 32'hA5C3_0F81, 32'h0, 0);
    add_vec("lw_last",    0, 3'b010, 32'(DEPTH*4-4), 32'h0,  32'hA5C30F81, 0);
    add_vec("lhu_last_hi",0, 3'b101, 32'(DEPTH*4-2), 32'h0,  32'h0000A5C3, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_checked(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr,
                  vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Backpressure: response held for 5 cycles, stray request ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp latency", 32'(lat), 32'(LAT));
    held = 32'h123455EF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'h0;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      check("bp rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp rsp_rdata", rsp_rdata, held);
      check("bp req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp state idle", 32'(dbg_state), 32'd0);
    run_checked("bp lw_after", 0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 0);

    // Reset in WAIT after an accepted store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    check("rst_mid state wait", 32'(dbg_state), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid req_ready", 32'(req_ready), 32'd0);
    check("rst_mid state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid release ready", 32'(req_ready), 32'd1);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0) stray++;
    end
    check("rst_mid no response", 32'(stray), 32'd0);
    run_checked("rst_mid lw_20", 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
